shift_sipo: RTL

//   Serial-in / parallel-out shift receiver: assembles WIDTH serial bits into a parallel word.

---
 rtl/shift_sipo_if.sv | 24 ++
 rtl/shift_sipo.sv | 108 ++++++++++
 2 files changed

// File: rtl/shift_sipo_if.sv
// Bundles the serial input side and the parallel output handshake of the
// shift_sipo receiver. The master drives bits and acceptance; the slave is the receiver.
interface shift_sipo_if #(
    parameter int WIDTH = 4
);
    logic             si;
    logic             si_valid;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             busy;
    logic             ovr;

    modport master (
        output si, si_valid, dir, q_ready,
        input  q, q_valid, busy, ovr
    );

    modport slave (
        input  si, si_valid, dir, q_ready,
        output q, q_valid, busy, ovr
    );
endinterface

// File: rtl/shift_sipo.sv
// Serial-in / parallel-out receiver: gathers WIDTH bits in a per-word bit order
// and hands the finished word off over a valid/ready handshake.
module shift_sipo #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    shift_sipo_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] sr_next;

    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] sr,
        input logic             bit_in,
        input logic             dir_right
    );
        return dir_right ? {bit_in, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bit_in};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ovr_q   <= ovr_d;
        end
    end

    // A new word always starts from an empty register with the bit order sampled now.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        ovr_d   = ovr_q;
        sr_next = shift_in(sr_q, bus.si, dir_q);

        unique case (state_q)
            IDLE: begin
                if (bus.si_valid) begin
                    dir_d   = bus.dir;
                    sr_d    = shift_in('0, bus.si, bus.dir);
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.si_valid) begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        q_d     = sr_next;
                        sr_d    = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        sr_d  = sr_next;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.q_ready) begin
                    if (bus.si_valid) begin
                        dir_d   = bus.dir;
                        sr_d    = shift_in('0, bus.si, bus.dir);
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.si_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.q       = q_q;
    assign bus.q_valid = (state_q == HOLD);
    assign bus.busy    = (state_q == SHIFT);
    assign bus.ovr     = ovr_q;
endmodule
